// File: rtl/ice40_reset_pkg.sv
// Shared types and default constants for the ice40 reset sequencer.
package ice40_reset_pkg;

  localparam int unsigned DEF_NUM_STAGES  = 4;
  localparam int unsigned DEF_STAGE_DLY   = 16;
  localparam int unsigned DEF_SOFT_HOLD   = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_WDT_W       = 20;

  typedef enum logic [2:0] {
    HOLD        = 3'd0,
    RELEASE     = 3'd1,
    RUN         = 3'd2,
    SOFT_ASSERT = 3'd3,
    ACK         = 3'd4
  } reset_state_e;

  // Larger of two unsigned values, for sizing shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ice40_resetn_sync.sv
// Async-assert / sync-deassert reset synchronizer producing srst_n.
module ice40_resetn_sync
  import ice40_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic resetn,
  output logic srst_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift ones in after release; clear the whole chain as soon as resetn drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign srst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ice40_reset_seq.sv
// Staged reset release sequencer with soft-reset handshake.
// Optional watchdog enabled by defining RESET_SEQ_WDT_EN.
module ice40_reset_seq
  import ice40_reset_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned STAGE_DLY   = DEF_STAGE_DLY,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned SOFT_HOLD   = DEF_SOFT_HOLD,
  parameter int unsigned WDT_W       = DEF_WDT_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  soft_req,
  input  logic                  wdt_kick,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  done,
  output logic                  soft_ack,
  output logic                  wdt_fired
);

  localparam int unsigned CNT_W = $clog2(max_u(STAGE_DLY, SOFT_HOLD)) + 1;
  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  srst_n;
  reset_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  wdt_trip_c;

  ice40_resetn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .srst_n(srst_n)
  );

  // Sequencer state register; srst_n asserts asynchronously with resetn.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    ack_d   = ack_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
          stage_d = NUM_STAGES'(1);
          cnt_d   = '0;
          idx_d   = IDX_W'(1);
          if (NUM_STAGES == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
          stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (soft_req || wdt_trip_c) begin
          state_d = SOFT_ASSERT;
          stage_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      SOFT_ASSERT: begin
        if (cnt_q == CNT_W'(SOFT_HOLD - 1)) begin
          state_d = ACK;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        if (!soft_req) begin
          state_d = HOLD;
          ack_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

`ifdef RESET_SEQ_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LAST = {WDT_W{1'b1}} - WDT_W'(1);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             fired_q, fired_d;

  // Trip on the edge where the counter would reach all-ones without a kick.
  assign wdt_trip_c = (state_q == RUN) && !wdt_kick && (wdt_cnt_q == WDT_LAST);

  // Watchdog counts only while staying in RUN; kick or leaving RUN clears it.
  always_comb begin
    wdt_cnt_d = '0;
    fired_d   = fired_q | wdt_trip_c;
    if ((state_q == RUN) && (state_d == RUN) && !wdt_kick) begin
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    end
  end

  // Watchdog registers; the fired flag is sticky until resetn.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wdt_cnt_q <= '0;
      fired_q   <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      fired_q   <= fired_d;
    end
  end

  assign wdt_fired = fired_q;
`else
  logic [WDT_W-1:0] wdt_unused_c;

  assign wdt_trip_c   = 1'b0;
  assign wdt_unused_c = {WDT_W{wdt_kick}};
  assign wdt_fired    = 1'b0;
`endif

  assign stage_resetn = stage_q;
  assign done         = done_q;
  assign soft_ack     = ack_q;

endmodule

// File: tb/tb_ice40_reset_seq.sv
// Self-checking bench for ice40_reset_seq: directed scenarios plus random
// soft requests, kicks and reset pulses against a timing-based reference model.
module tb_ice40_reset_seq;

  localparam int unsigned NS = 4;
  localparam int unsigned SD = 16;
  localparam int unsigned SS = 2;
  localparam int unsigned SH = 8;
  localparam int unsigned WW = 6;
`ifdef RESET_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          soft_req = 1'b0;
  logic          wdt_kick = 1'b0;
  logic [NS-1:0] stage_resetn;
  logic          done;
  logic          soft_ack;
  logic          wdt_fired;

  int n_tests = 0;
  int n_fail  = 0;

  ice40_reset_seq #(
    .NUM_STAGES (NS),
    .STAGE_DLY  (SD),
    .SYNC_STAGES(SS),
    .SOFT_HOLD  (SH),
    .WDT_W      (WW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .soft_req    (soft_req),
    .wdt_kick    (wdt_kick),
    .stage_resetn(stage_resetn),
    .done        (done),
    .soft_ack    (soft_ack),
    .wdt_fired   (wdt_fired)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus elapsed edges since the phase began.
  localparam int M_RST = 0, M_SEQ = 1, M_RUN = 2, M_SOFT = 3, M_ACK = 4;
  int m_mode  = M_RST;
  int m_rel   = 0;
  int m_t     = 0;
  int m_wdt   = 0;
  bit m_fired = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_rst();
    m_mode  = M_RST;
    m_rel   = 0;
    m_wdt   = 0;
    m_fired = 1'b0;
  endtask

  task automatic model_edge();
    bit trip;
    if (!resetn) begin
      model_rst();
    end else begin
      case (m_mode)
        M_RST: begin
          m_rel++;
          if (m_rel == int'(SS)) begin
            m_mode = M_SEQ;
            m_t    = 0;
          end
        end
        M_SEQ: begin
          m_t++;
          if (m_t >= int'(NS * SD)) begin
            m_mode = M_RUN;
            m_wdt  = 0;
          end
        end
        M_RUN: begin
          trip = WDT_ON && !wdt_kick && (m_wdt + 1 == (1 << WW) - 1);
          if (soft_req || trip) begin
            m_mode = M_SOFT;
            m_t    = 0;
            if (trip) m_fired = 1'b1;
          end else begin
            m_wdt = wdt_kick ? 0 : m_wdt + 1;
          end
        end
        M_SOFT: begin
          m_t++;
          if (m_t == int'(SH)) m_mode = M_ACK;
        end
        default: begin
          if (!soft_req) begin
            m_mode = M_SEQ;
            m_t    = 0;
          end
        end
      endcase
    end
  endtask

  function automatic logic [NS-1:0] exp_stage();
    int k;
    if (m_mode == M_SEQ) begin
      k = m_t / int'(SD);
      if (k > int'(NS)) k = int'(NS);
      return NS'((1 << k) - 1);
    end else if (m_mode == M_RUN) begin
      return '1;
    end
    return '0;
  endfunction

  task automatic check_outs();
    chk("m_stage", 32'(stage_resetn), 32'(exp_stage()));
    chk("m_done",  32'(done),         32'(m_mode == M_RUN));
    chk("m_ack",   32'(soft_ack),     32'(m_mode == M_ACK));
    chk("m_fired", 32'(wdt_fired),    32'(m_fired));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  // Drop resetn between edges and confirm the outputs clear with no clock.
  task automatic async_rst(input string tag);
    @(negedge clk);
    #2;
    resetn   = 1'b0;
    soft_req = 1'b0;
    wdt_kick = 1'b0;
    #1;
    model_rst();
    chk(tag, 32'({stage_resetn, done, soft_ack, wdt_fired}), 32'h0);
  endtask

  // Release resetn and check the staged release edges; optionally abort.
  task automatic run_release(input string tag, input int abort_at);
    @(negedge clk);
    resetn = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      if (e == abort_at) begin
        async_rst({tag, "_abort"});
        return;
      end
      step();
      case (e)
        17: chk({tag, "_e17"}, 32'(stage_resetn), 32'h0);
        18: chk({tag, "_e18"}, 32'(stage_resetn), 32'h1);
        33: chk({tag, "_e33"}, 32'(stage_resetn), 32'h1);
        34: chk({tag, "_e34"}, 32'(stage_resetn), 32'h3);
        50: chk({tag, "_e50"}, 32'(stage_resetn), 32'h7);
        65: chk({tag, "_e65"}, 32'({stage_resetn, done}), 32'he);
        66: chk({tag, "_e66"}, 32'({stage_resetn, done}), 32'h1f);
        default: ;
      endcase
    end
  endtask

  initial begin
    // Power-up with defaults
    #2;
    resetn = 1'b0;
    #1;
    chk("por_async", 32'({stage_resetn, done, soft_ack, wdt_fired}), 32'h0);
    repeat (5) step();
    run_release("pu", 0);

    // Soft reset handshake
    @(negedge clk);
    soft_req = 1'b1;
    step();
    chk("soft_assert", 32'({stage_resetn, done}), 32'h0);
    for (int i = 1; i <= int'(SH); i++) begin
      step();
      if (i == int'(SH) - 1) chk("soft_ack_early", 32'(soft_ack), 32'h0);
      if (i == int'(SH))     chk("soft_ack_high",  32'(soft_ack), 32'h1);
    end
    @(negedge clk);
    soft_req = 1'b0;
    step();
    chk("soft_ack_drop", 32'(soft_ack), 32'h0);
    for (int i = 1; i <= int'(SD); i++) begin
      step();
      if (i == int'(SD) - 1) chk("soft_stg0_early", 32'(stage_resetn), 32'h0);
      if (i == int'(SD))     chk("soft_stg0_rise",  32'(stage_resetn), 32'h1);
    end

    // Early request during RELEASE is held off until RUN
    @(negedge clk);
    soft_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) break;
    end
    chk("early_done", 32'({stage_resetn, done}), 32'h1f);
    step();
    chk("early_soft", 32'({stage_resetn, done}), 32'h0);

    // Reset during SOFT_ASSERT, then during RELEASE, then a clean run
    repeat (3) step();
    async_rst("rst_soft");
    repeat (3) step();
    run_release("rst_rel", 40);
    repeat (2) step();
    run_release("rst_full", 0);

    // Watchdog: no kicks after entering RUN at edge 66
    for (int i = 1; i <= 59; i++) begin
      step();
      if (i == 58) chk("wdt_e62", 32'(wdt_fired), 32'h0);
      if (i == 59) begin
        chk("wdt_e63_fired", 32'(wdt_fired), 32'(WDT_ON));
        chk("wdt_e63_stg", 32'(stage_resetn), WDT_ON ? 32'h0 : 32'hf);
      end
    end

    // Randomized requests, kicks and reset pulses
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_rst("rnd_rst");
        repeat ($urandom_range(1, 3)) step();
        @(negedge clk);
        resetn = 1'b1;
        step();
      end else begin
        @(negedge clk);
        if (!soft_req) begin
          soft_req = ($urandom_range(0, 59) == 0);
        end else if (soft_ack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0)) begin
          soft_req = 1'b0;
        end
        wdt_kick = ($urandom_range(0, 24) == 0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
